// File: rtl/acc_exec_stage.sv
// ---------------------------------------------------------------------------
// acc_exec_stage
//
// Execute stage of the AZ accumulator CPU. It sits directly after the
// fetch/decode stage. It owns the program counter, the accumulator, the Z/C
// flags and a private data memory. One instruction runs per fetch request.
// The fetch_en pulse asks the fetch stage for the instruction at pc. A rising
// edge on is_ready hands over {control_bus, data}. The instruction then runs
// through EXEC (memory access) and WB (architectural update). After WB the
// next fetch is requested.
//
// Parameters
//   INST_CAP    instruction memory depth; pc wraps INST_CAP-1 -> 0
//   DATA_LEN    accumulator / operand / data-memory word width
//   DMEM_DEPTH  data memory words, addressed by the low bits of data
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active-high
//   is_ready     in   decode-stage ready level; a 0->1 edge marks a new instruction
//   control_bus  in   4-bit opcode
//   data         in   address or immediate operand
//   fetch_en     out  one-cycle request to the fetch stage
//   pc           out  address of the instruction to fetch
//   acc          out  accumulator
//   flag_z       out  zero flag
//   flag_c       out  carry / borrow / shifted-out bit
//   halted       out  high once HLT has executed
//   retired      out  retired-instruction count
//
// Optional feature
//   ACC_EXEC_RETIRE_CNT_EN  when defined, retired counts every instruction
//                           that completes WB and saturates at 16'hFFFF.
//                           When it is undefined, retired is tied to zero.
// ---------------------------------------------------------------------------
module acc_exec_stage #(
    parameter int INST_CAP   = 20,
    parameter int DATA_LEN   = 8,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        is_ready,
    input  logic [3:0]                  control_bus,
    input  logic [DATA_LEN-1:0]         data,
    output logic                        fetch_en,
    output logic [$clog2(INST_CAP):0]   pc,
    output logic [DATA_LEN-1:0]         acc,
    output logic                        flag_z,
    output logic                        flag_c,
    output logic                        halted,
    output logic [15:0]                 retired
);

    localparam int PC_W = $clog2(INST_CAP) + 1;
    localparam int AW   = $clog2(DMEM_DEPTH);

    localparam logic [2:0] ST_ISSUE = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WB    = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam logic [3:0] OP_STA  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_LDI  = 4'b0110;
    localparam logic [3:0] OP_ADDI = 4'b0111;
    localparam logic [3:0] OP_NOP  = 4'b1000;
    localparam logic [3:0] OP_JMP  = 4'b1001;
    localparam logic [3:0] OP_JZ   = 4'b1010;
    localparam logic [3:0] OP_JC   = 4'b1011;
    localparam logic [3:0] OP_NOT  = 4'b1100;
    localparam logic [3:0] OP_SHL  = 4'b1101;
    localparam logic [3:0] OP_SHR  = 4'b1110;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    logic [2:0]          state;
    logic                is_ready_q;
    logic [3:0]          op_q;
    logic [DATA_LEN-1:0] opnd_q;
    logic [DATA_LEN-1:0] mem_q;
    logic [DATA_LEN-1:0] dmem [DMEM_DEPTH];
    logic [AW-1:0]       addr;

    logic [DATA_LEN-1:0] acc_nx;
    logic                z_nx;
    logic                c_nx;
    logic [PC_W-1:0]     pc_nx;
    logic [PC_W-1:0]     pc_inc;
    logic [PC_W-1:0]     jump_tgt;
    logic [DATA_LEN:0]   sum;
    logic [DATA_LEN:0]   diff;
    logic                writes_acc;

    // Upper operand bits above the memory address width are ignored.
    assign addr = opnd_q[AW-1:0];

    // Sequential pc with wrap. Jump targets beyond the instruction memory
    // restart the program at 0 instead of running off the end.
    assign pc_inc   = (pc == PC_W'(INST_CAP - 1)) ? '0 : pc + PC_W'(1);
    assign jump_tgt = (opnd_q >= DATA_LEN'(INST_CAP)) ? '0 : PC_W'(opnd_q);

    // ADD uses the memory word and ADDI uses the immediate. Both share one
    // adder. The extra top bit of the adder is the carry out. For SUB, the
    // same top bit of a zero-extended difference is the borrow (acc < M).
    assign sum  = {1'b0, acc} + {1'b0, (op_q == OP_ADDI) ? opnd_q : mem_q};
    assign diff = {1'b0, acc} - {1'b0, mem_q};

    // Write-back values for the instruction held in op_q/opnd_q. Only the
    // arithmetic and shift ops touch C. Every op that writes acc recomputes Z.
    always_comb begin
        acc_nx     = acc;
        c_nx       = flag_c;
        pc_nx      = pc_inc;
        writes_acc = 1'b0;
        case (op_q)
            OP_LDA:  begin acc_nx = mem_q;          writes_acc = 1'b1; end
            OP_ADD,
            OP_ADDI: begin
                acc_nx     = sum[DATA_LEN-1:0];
                c_nx       = sum[DATA_LEN];
                writes_acc = 1'b1;
            end
            OP_SUB:  begin
                acc_nx     = diff[DATA_LEN-1:0];
                c_nx       = diff[DATA_LEN];
                writes_acc = 1'b1;
            end
            OP_AND:  begin acc_nx = acc & mem_q;    writes_acc = 1'b1; end
            OP_OR:   begin acc_nx = acc | mem_q;    writes_acc = 1'b1; end
            OP_LDI:  begin acc_nx = opnd_q;         writes_acc = 1'b1; end
            OP_JMP:  pc_nx = jump_tgt;
            OP_JZ:   if (flag_z) pc_nx = jump_tgt;
            OP_JC:   if (flag_c) pc_nx = jump_tgt;
            OP_NOT:  begin acc_nx = ~acc;           writes_acc = 1'b1; end
            OP_SHL:  begin
                acc_nx     = {acc[DATA_LEN-2:0], 1'b0};
                c_nx       = acc[DATA_LEN-1];
                writes_acc = 1'b1;
            end
            OP_SHR:  begin
                acc_nx     = {1'b0, acc[DATA_LEN-1:1]};
                c_nx       = acc[0];
                writes_acc = 1'b1;
            end
            OP_HLT:  pc_nx = pc;
            default: ;
        endcase
        z_nx = writes_acc ? (acc_nx == '0) : flag_z;
    end

    // Main control FSM.
    // Out of reset, ISSUE spends one cycle raising fetch_en and then holds it
    // for one cycle. Leaving WB, fetch_en is raised together with the move to
    // ISSUE, so the request appears the cycle after WB. In both cases fetch_en
    // is high for exactly one cycle. The ready edge detector runs in every
    // live state. This stops a ready level that is still high from the
    // previous instruction from triggering a second execution.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_ISSUE;
            fetch_en   <= 1'b0;
            pc         <= '0;
            acc        <= '0;
            flag_z     <= 1'b0;
            flag_c     <= 1'b0;
            halted     <= 1'b0;
            is_ready_q <= 1'b0;
            op_q       <= OP_NOP;
            opnd_q     <= '0;
        end else begin
            if (state != ST_HALT) is_ready_q <= is_ready;
            case (state)
                ST_ISSUE: begin
                    if (!fetch_en) begin
                        fetch_en <= 1'b1;
                    end else begin
                        fetch_en <= 1'b0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (is_ready && !is_ready_q) begin
                        op_q   <= control_bus;
                        opnd_q <= data;
                        state  <= ST_EXEC;
                    end
                end
                ST_EXEC: state <= ST_WB;
                ST_WB: begin
                    acc    <= acc_nx;
                    flag_z <= z_nx;
                    flag_c <= c_nx;
                    pc     <= pc_nx;
                    if (op_q == OP_HLT) begin
                        halted <= 1'b1;
                        state  <= ST_HALT;
                    end else begin
                        fetch_en <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_HALT: ;
                default: state <= ST_ISSUE;
            endcase
        end
    end

    // Data memory. Reads are synchronous and are issued in EXEC, so mem_q is
    // valid during WB. A STA write also happens on the EXEC edge. Reset
    // blocks the write, so an instruction cut off by reset leaves memory
    // untouched. Memory contents are not cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst && state == ST_EXEC) begin
            if (op_q == OP_STA) dmem[addr] <= acc;
            mem_q <= dmem[addr];
        end
    end

`ifdef ACC_EXEC_RETIRE_CNT_EN
    // Counts every instruction that reaches WB, including NOP and HLT.
    // The count sticks at the top value instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired <= 16'h0000;
        end else if (state == ST_WB && retired != 16'hFFFF) begin
            retired <= retired + 16'h0001;
        end
    end
`else
    assign retired = 16'h0000;
`endif

endmodule

// File: tb/tb_acc_exec_stage.sv
// ---------------------------------------------------------------------------
// tb_acc_exec_stage
//
// Self-checking bench for acc_exec_stage. The bench plays the fetch/decode
// stage: it waits for fetch_en, presents an opcode and operand, and raises
// is_ready. A behavioural model of the accumulator machine uses integer
// arithmetic and a memory array. The outputs of the design are compared
// against that model and against hand-derived constants.
// If ACC_EXEC_RETIRE_CNT_EN is defined, the model also counts retired
// instructions.
// ---------------------------------------------------------------------------
module tb_acc_exec_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_ready;
    logic [3:0]  control_bus;
    logic [7:0]  data;
    logic        fetch_en;
    logic [5:0]  pc;
    logic [7:0]  acc;
    logic        flag_z;
    logic        flag_c;
    logic        halted;
    logic [15:0] retired;

    int vectors     = 0;
    int miscompares = 0;

    // Reference machine state
    int m_acc, m_z, m_c, m_pc, m_halted, m_retired;
    int m_mem [256];
    bit in_wait;

    acc_exec_stage #(.INST_CAP(20), .DATA_LEN(8), .DMEM_DEPTH(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .is_ready    (is_ready),
        .control_bus (control_bus),
        .data        (data),
        .fetch_en    (fetch_en),
        .pc          (pc),
        .acc         (acc),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .halted      (halted),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    // Architectural reference: one call per instruction handed over.
    task automatic model_step(input int op, input int d);
        int s;
        bit taken;
        taken = 1'b0;
        case (op)
            0:  begin m_acc = m_mem[d]; m_z = (m_acc == 0); end
            1:  m_mem[d] = m_acc;
            2:  begin s = m_acc + m_mem[d]; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
            3:  begin m_c = (m_acc < m_mem[d]); m_acc = (m_acc - m_mem[d] + 256) % 256; m_z = (m_acc == 0); end
            4:  begin m_acc = m_acc & m_mem[d]; m_z = (m_acc == 0); end
            5:  begin m_acc = m_acc | m_mem[d]; m_z = (m_acc == 0); end
            6:  begin m_acc = d; m_z = (m_acc == 0); end
            7:  begin s = m_acc + d; m_c = (s > 255); m_acc = s % 256; m_z = (m_acc == 0); end
            9:  taken = 1'b1;
            10: taken = (m_z != 0);
            11: taken = (m_c != 0);
            12: begin m_acc = 255 - m_acc; m_z = (m_acc == 0); end
            13: begin m_c = (m_acc >= 128); m_acc = (m_acc * 2) % 256; m_z = (m_acc == 0); end
            14: begin m_c = m_acc % 2; m_acc = m_acc / 2; m_z = (m_acc == 0); end
            15: m_halted = 1;
            default: ;
        endcase
        if (op == 15)     ;
        else if (taken)   m_pc = (d >= 20) ? 0 : d;
        else              m_pc = (m_pc + 1) % 20;
`ifdef ACC_EXEC_RETIRE_CNT_EN
        if (m_retired < 65535) m_retired++;
`endif
    endtask

    task automatic model_reset();
        m_acc = 0; m_z = 0; m_c = 0; m_pc = 0; m_halted = 0; m_retired = 0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; is_ready = 1'b0; control_bus = 4'b1000; data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        in_wait = 1'b0;
    endtask

    task automatic wait_fetch();
        int n;
        n = 0;
        while (!fetch_en && n < 40) begin @(negedge clk); n++; end
        if (!fetch_en) begin
            vectors++; miscompares++;
            $display("[TB] FAIL fetch_timeout: fetch_en=%b required 1", fetch_en);
        end
    endtask

    // Hands one instruction to the stage, like a decode stage would, and
    // returns once the stage asks for the next one (or has halted).
    task automatic run_instr(input logic [3:0] op, input logic [7:0] d);
        int n;
        if (!in_wait) wait_fetch();
        in_wait = 1'b0;
        control_bus = op; data = d; is_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        is_ready = 1'b1;
        @(negedge clk);
        is_ready = 1'b0;
        model_step(int'(op), int'(d));
        n = 0;
        while (!fetch_en && !halted && n < 40) begin @(negedge clk); n++; end
        if (!fetch_en && !halted) begin
            vectors++; miscompares++;
            $display("[TB] FAIL done_timeout: op=%h fetch_en=%b halted=%b required completion", op, fetch_en, halted);
        end
    endtask

    task automatic test_reset();
        int highs;
        rst = 1'b1; is_ready = 1'b0; control_bus = 4'b1000; data = 8'h00;
        repeat (2) @(negedge clk);
        vectors++; if (pc !== 6'd0)      begin miscompares++; $display("[TB] FAIL reset_pc: got %0d required 0", pc); end
        vectors++; if (acc !== 8'h00)    begin miscompares++; $display("[TB] FAIL reset_acc: got %h required 00", acc); end
        vectors++; if ({flag_z, flag_c} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_flags: got %b required 00", {flag_z, flag_c}); end
        vectors++; if (halted !== 1'b0)  begin miscompares++; $display("[TB] FAIL reset_halted: got %b required 0", halted); end
        vectors++; if (fetch_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_fetch_en: got %b required 0", fetch_en); end
        vectors++; if (retired !== 16'h0) begin miscompares++; $display("[TB] FAIL reset_retired: got %h required 0000", retired); end
        rst = 1'b0;
        model_reset();
        highs = 0;
        repeat (6) begin @(negedge clk); if (fetch_en === 1'b1) highs++; end
        vectors++; if (highs != 1) begin miscompares++; $display("[TB] FAIL reset_fetch_pulse: got %0d high cycles required 1", highs); end
        in_wait = 1'b1;
    endtask

    task automatic test_program_halt();
        apply_reset();
        run_instr(4'b0110, 8'h0F);
        run_instr(4'b0111, 8'hF1);
        run_instr(4'b1111, 8'h00);
        vectors++; if (acc !== 8'h00)   begin miscompares++; $display("[TB] FAIL halt_acc: got %h required 00", acc); end
        vectors++; if ({flag_z, flag_c} !== 2'b11) begin miscompares++; $display("[TB] FAIL halt_flags: got %b required 11", {flag_z, flag_c}); end
        vectors++; if (halted !== 1'b1) begin miscompares++; $display("[TB] FAIL halt_halted: got %b required 1", halted); end
        vectors++; if (pc !== 6'd2)     begin miscompares++; $display("[TB] FAIL halt_pc: got %0d required 2", pc); end
        vectors++; if (retired !== 16'(m_retired)) begin miscompares++; $display("[TB] FAIL halt_retired: got %0d required %0d", retired, m_retired); end
        // A new instruction offered while halted must be ignored.
        control_bus = 4'b0110; data = 8'h55; is_ready = 1'b0;
        repeat (2) @(negedge clk);
        is_ready = 1'b1;
        repeat (8) @(negedge clk);
        is_ready = 1'b0;
        vectors++; if (acc !== 8'h00 || pc !== 6'd2 || fetch_en !== 1'b0 || halted !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL halt_frozen: acc=%h pc=%0d fetch_en=%b halted=%b required 00/2/0/1", acc, pc, fetch_en, halted);
        end
    endtask

    task automatic test_mem_ops();
        apply_reset();
        run_instr(4'b0110, 8'd5);
        run_instr(4'b0001, 8'h10);
        run_instr(4'b0110, 8'd0);
        run_instr(4'b0000, 8'h10);
        vectors++; if (acc !== 8'd5) begin miscompares++; $display("[TB] FAIL mem_lda: got %h required 05", acc); end
        run_instr(4'b0011, 8'h10);
        vectors++; if (acc !== 8'h00) begin miscompares++; $display("[TB] FAIL mem_sub_acc: got %h required 00", acc); end
        vectors++; if ({flag_z, flag_c} !== 2'b10) begin miscompares++; $display("[TB] FAIL mem_sub_flags: got %b required 10", {flag_z, flag_c}); end
        vectors++; if (pc !== 6'd5) begin miscompares++; $display("[TB] FAIL mem_pc: got %0d required 5", pc); end
    endtask

    task automatic test_pc_wrap();
        apply_reset();
        run_instr(4'b1001, 8'd19);
        vectors++; if (pc !== 6'd19) begin miscompares++; $display("[TB] FAIL jmp19_pc: got %0d required 19", pc); end
        run_instr(4'b1000, 8'd0);
        vectors++; if (pc !== 6'd0)  begin miscompares++; $display("[TB] FAIL wrap_pc: got %0d required 0", pc); end
        run_instr(4'b1001, 8'd25);
        vectors++; if (pc !== 6'd0)  begin miscompares++; $display("[TB] FAIL jmp_oob_pc: got %0d required 0", pc); end
        run_instr(4'b0110, 8'd1);
        run_instr(4'b1010, 8'd7);
        vectors++; if (pc !== 6'd2)  begin miscompares++; $display("[TB] FAIL jz_not_taken_pc: got %0d required 2", pc); end
        run_instr(4'b0110, 8'd0);
        run_instr(4'b1010, 8'd7);
        vectors++; if (pc !== 6'd7)  begin miscompares++; $display("[TB] FAIL jz_taken_pc: got %0d required 7", pc); end
    endtask

    task automatic test_level_ready();
        apply_reset();
        run_instr(4'b0110, 8'd3);
        // One edge, then ready stays high well past the instruction's end.
        control_bus = 4'b1000; data = 8'h00; is_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        is_ready = 1'b1;
        repeat (10) @(negedge clk);
        is_ready = 1'b0;
        model_step(8, 0);
        repeat (4) @(negedge clk);
        vectors++; if (pc !== 6'd2) begin miscompares++; $display("[TB] FAIL level_single_exec_pc: got %0d required 2", pc); end
        in_wait = 1'b1;
        run_instr(4'b0111, 8'd1);
        vectors++; if (acc !== 8'd4 || pc !== 6'd3) begin miscompares++; $display("[TB] FAIL level_resume: acc=%h pc=%0d required 04/3", acc, pc); end
        vectors++; if (retired !== 16'(m_retired)) begin miscompares++; $display("[TB] FAIL level_retired: got %0d required %0d", retired, m_retired); end
    endtask

    task automatic test_reset_mid_sta();
        apply_reset();
        run_instr(4'b0110, 8'h33);
        run_instr(4'b0001, 8'h20);
        run_instr(4'b0110, 8'h44);
        wait_fetch();
        control_bus = 4'b0001; data = 8'h20; is_ready = 1'b0;
        @(negedge clk); @(negedge clk);
        is_ready = 1'b1;
        @(negedge clk);
        // The stage is now in EXEC of the STA. Reset on the write edge.
        rst = 1'b1; is_ready = 1'b0;
        @(negedge clk);
        vectors++; if (acc !== 8'h00 || pc !== 6'd0 || {flag_z, flag_c} !== 2'b00 || halted !== 1'b0 || fetch_en !== 1'b0 || retired !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL midsta_reset_outputs: acc=%h pc=%0d zc=%b halted=%b fetch_en=%b retired=%h required all zero",
                     acc, pc, {flag_z, flag_c}, halted, fetch_en, retired);
        end
        rst = 1'b0;
        model_reset();
        in_wait = 1'b0;
        run_instr(4'b0000, 8'h20);
        vectors++; if (acc !== 8'h33) begin miscompares++; $display("[TB] FAIL midsta_no_write: got %h required 33", acc); end
    endtask

    task automatic test_shift_not();
        apply_reset();
        run_instr(4'b0110, 8'h81);
        run_instr(4'b1101, 8'h00);
        vectors++; if (acc !== 8'h02 || flag_c !== 1'b1) begin miscompares++; $display("[TB] FAIL shl: acc=%h c=%b required 02/1", acc, flag_c); end
        run_instr(4'b1110, 8'h00);
        vectors++; if (acc !== 8'h01 || flag_c !== 1'b0) begin miscompares++; $display("[TB] FAIL shr: acc=%h c=%b required 01/0", acc, flag_c); end
        run_instr(4'b1100, 8'h00);
        vectors++; if (acc !== 8'hFE || flag_z !== 1'b0) begin miscompares++; $display("[TB] FAIL not: acc=%h z=%b required FE/0", acc, flag_z); end
    endtask

    task automatic test_random();
        logic [3:0] op;
        logic [7:0] d;
        apply_reset();
        // Give the addresses used below defined contents first.
        for (int a = 0; a < 8; a++) begin
            run_instr(4'b0110, 8'($urandom_range(0, 255)));
            run_instr(4'b0001, 8'(a));
        end
        for (int i = 0; i < 150; i++) begin
            op = 4'($urandom_range(0, 14));
            if (op <= 4'd5)                      d = 8'($urandom_range(0, 7));
            else if (op >= 4'd9 && op <= 4'd11)  d = 8'($urandom_range(0, 31));
            else                                 d = 8'($urandom_range(0, 255));
            run_instr(op, d);
            vectors++; if (acc !== 8'(m_acc)) begin miscompares++; $display("[TB] FAIL rand_acc[%0d] op=%h d=%h: got %h required %h", i, op, d, acc, 8'(m_acc)); end
            vectors++; if ({flag_z, flag_c} !== {1'(m_z), 1'(m_c)}) begin miscompares++; $display("[TB] FAIL rand_flags[%0d] op=%h d=%h: got %b required %b%b", i, op, d, {flag_z, flag_c}, 1'(m_z), 1'(m_c)); end
            vectors++; if (pc !== 6'(m_pc)) begin miscompares++; $display("[TB] FAIL rand_pc[%0d] op=%h d=%h: got %0d required %0d", i, op, d, pc, m_pc); end
        end
        vectors++; if (retired !== 16'(m_retired)) begin miscompares++; $display("[TB] FAIL rand_retired: got %0d required %0d", retired, m_retired); end
        vectors++; if (halted !== 1'b0) begin miscompares++; $display("[TB] FAIL rand_halted: got %b required 0", halted); end
    endtask

    initial begin
        rst = 1'b1; is_ready = 1'b0; control_bus = 4'b1000; data = 8'h00;
        in_wait = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_program_halt();
        test_mem_ops();
        test_pc_wrap();
        test_level_ready();
        test_reset_mid_sta();
        test_shift_not();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, %0d miscompares so far", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
